// File: rtl/gray_pkg.sv
// gray_pkg: shared types, defaults and Gray decode helper for Gray-code consumers.
package gray_pkg;
  localparam int DEF_WIDTH = 3;
  localparam int DEF_MAX_COUNT = 6;
  typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;
  function automatic logic [DEF_WIDTH-1:0] gray2bin(input logic [DEF_WIDTH-1:0] g);
    logic [DEF_WIDTH-1:0] b;
    for (int i = 0; i < DEF_WIDTH; i++) b[i] = ^(g >> i);
    return b;
  endfunction
endpackage

// File: rtl/gray_seq_checker_if.sv
// gray_seq_checker_if: Gray word/enable inputs and status outputs of the sequence checker.
interface gray_seq_checker_if #(
  parameter int WIDTH = 3,
  parameter int ERR_CNT_W = 8
);
  logic [WIDTH-1:0] gray_in;
  logic en_in;
  logic clr_err;
  logic [WIDTH-1:0] bin_out;
  logic bin_valid;
  logic wrap_pulse;
  logic step_err;
  logic err_sticky;
  logic [ERR_CNT_W-1:0] err_count;
  logic locked;
  modport master (
    output gray_in, en_in, clr_err,
    input bin_out, bin_valid, wrap_pulse, step_err, err_sticky, err_count, locked
  );
  modport slave (
    input gray_in, en_in, clr_err,
    output bin_out, bin_valid, wrap_pulse, step_err, err_sticky, err_count, locked
  );
endinterface

// File: rtl/gray2bin_conv.sv
// gray2bin_conv: combinational Gray-to-binary decoder of any width.
module gray2bin_conv #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end
endmodule

// File: rtl/gray_seq_checker.sv
// gray_seq_checker: decodes the upstream Gray counter and flags illegal steps.
module gray_seq_checker
  import gray_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MAX_COUNT = DEF_MAX_COUNT,
  parameter int LOCK_CYCLES = 2,
  parameter int ERR_CNT_W = 8
) (
  input logic clk,
  input logic rst,
  gray_seq_checker_if.slave bus
);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  state_t state;
  logic [WIDTH-1:0] b, bin_q, exp_b;
  logic [LW-1:0] lock_cnt;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic en_q, legal, wrap, err, valid, wrap_p, step_p, sticky, lck;
  gray2bin_conv #(.WIDTH(WIDTH)) u_conv (.gray(bus.gray_in), .bin(b));
  always_comb begin
    exp_b = !en_q ? '0 : (bin_q == MAX_W) ? '0 : bin_q + WIDTH'(1);
    legal = (b == exp_b) && (b <= MAX_W);
    wrap = en_q && (bin_q == MAX_W) && (b == '0);
    err = (state == TRACK) && !legal;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
      bin_q <= '0;
      en_q <= 1'b0;
      lock_cnt <= '0;
      err_cnt <= '0;
      valid <= 1'b0;
      wrap_p <= 1'b0;
      step_p <= 1'b0;
      sticky <= 1'b0;
      lck <= 1'b0;
    end else begin
      bin_q <= b;
      en_q <= bus.en_in;
      step_p <= err;
      wrap_p <= (state == TRACK) && legal && wrap;
      // an error on the same edge as clr_err still counts as the first error
      sticky <= err ? 1'b1 : bus.clr_err ? 1'b0 : sticky;
      err_cnt <= err ? (bus.clr_err ? ERR_CNT_W'(1) : &err_cnt ? err_cnt : err_cnt + ERR_CNT_W'(1))
               : bus.clr_err ? '0 : err_cnt;
      case (state)
        INIT: begin
          state <= TRACK;
          valid <= 1'b1;
          lck <= 1'b1;
        end
        TRACK: if (!legal) begin
          state <= FAULT;
          lck <= 1'b0;
          lock_cnt <= '0;
        end
        FAULT: if (!legal) lock_cnt <= '0;
        else if (lock_cnt == LOCK_LAST) begin
          state <= TRACK;
          lck <= 1'b1;
          lock_cnt <= '0;
        end else lock_cnt <= lock_cnt + LW'(1);
        default: state <= INIT;
      endcase
    end
  end
  assign bus.bin_out = bin_q;
  assign bus.bin_valid = valid;
  assign bus.wrap_pulse = wrap_p;
  assign bus.step_err = step_p;
  assign bus.err_sticky = sticky;
  assign bus.err_count = err_cnt;
  assign bus.locked = lck;
endmodule

// File: doc/gray_seq_checker.md
Name: gray_seq_checker

Overview:
- Downstream consumer of the 3-bit Gray counter.
- Samples the Gray word and the counter's enable every clock, converts the word to binary, and checks each transition against the counter's legal sequence. Legal sequence: binary 0..MAX_COUNT, then wrap to 0, with a forced 0 whenever enable is low.
- Reports binary value, wrap events, and step errors (pulse, sticky, saturating count) to the system status logic.

Parameters:
- WIDTH, 3, Gray/binary word width.
- MAX_COUNT, 6, terminal binary value of the upstream counter; the next step is 0.
- LOCK_CYCLES, 2, consecutive legal transitions required to leave FAULT.
- ERR_CNT_W, 8, error counter width.

Ports:
- clk  in  1  rising-edge clock, shared with the counter.
- rst  in  1  asynchronous, active-low reset.
- gray_in  in  WIDTH  Gray word from the counter output.
- en_in  in  1  same enable signal that drives the counter.
- clr_err  in  1  synchronous clear of err_sticky and err_count.
- bin_out  out  WIDTH  registered binary of the last sampled gray_in.
- bin_valid  out  1  bin_out holds a sampled value.
- wrap_pulse  out  1  one-cycle pulse on a legal MAX_COUNT->0 step.
- step_err  out  1  one-cycle pulse on the first illegal transition.
- err_sticky  out  1  set by any error; cleared only by clr_err or reset.
- err_count  out  ERR_CNT_W  saturating count of flagged errors.
- locked  out  1  high while the FSM is in TRACK.

Behaviour:
- Reset (rst=0, async): all outputs 0, bin_q=0, en_q=0, lock counter 0, state INIT.
- Each rising edge:
  - b = gray2bin(gray_in), where b[i] = XOR of gray_in[WIDTH-1:i].
  - bin_out <= b and en_q <= en_in.
  - Latency is one cycle from gray_in to bin_out and all flags.
- Expected value for the current sample:
  - en_q=1: expected = (bin_q==MAX_COUNT) ? 0 : bin_q+1.
  - en_q=0: expected = 0.
  - en_q is the enable the counter itself sampled on the previous edge.
- Illegal sample: b != expected, OR b > MAX_COUNT (range error, e.g. gray 100 = binary 7). Range error takes the same error path.
- Out-of-range values are still presented on bin_out.
- FSM:
  - INIT:
    - First edge after reset captures b with no check, sets bin_valid=1, goes to TRACK.
  - TRACK (locked=1):
    - Legal sample: stay in TRACK.
    - Legal wrap (en_q=1, bin_q=MAX_COUNT, b=0) asserts wrap_pulse. A forced 0 with en_q=0 is not a wrap.
    - Illegal sample: step_err=1 for one cycle, err_sticky<=1, err_count+1 (saturates at all-ones), lock counter cleared, go to FAULT.
  - FAULT (locked=0):
    - Reference always resyncs to b; no step_err and no count increments.
    - Each legal transition increments the lock counter; an illegal one clears it.
    - Reaching LOCK_CYCLES moves the FSM to TRACK.
- clr_err=1 clears err_sticky and err_count on that edge. If an error occurs on the same edge, the error wins: sticky=1, count=1.
- FSM state and bin_out are unaffected by clr_err.
- Reset mid-stream returns to INIT immediately, so the first post-reset sample is never flagged.
- Held value with en_q=1 is illegal, because the counter always steps while enabled.

Decomposition:
- Package gray_pkg holds:
  - the state enum {INIT, TRACK, FAULT};
  - a gray2bin function;
  - default MAX_COUNT and WIDTH constants.
- One natural sub-module: gray2bin_conv, purely combinational and WIDTH-parameterised, reusable by other Gray consumers.

Test Plan:
- Reset, then en_in=1 with the counter model stepping gray 000,001,011,010,110,111,101,000 -> bin_out 0..6,0. wrap_pulse exactly once, on bin_out=0 after 6. No step_err; locked=1 from cycle 2.
- en_in dropped to 0 while bin=4 (gray 110), next gray 000 -> no error, no wrap_pulse, bin_out=0.
- Inject gray 011 (bin 2) where bin 4 is expected -> step_err one cycle, err_sticky=1, err_count=1, locked=0. Two legal steps follow -> locked=1.
- Inject gray 100 (bin 7) -> range error flagged, bin_out=7, err_count increments. A second bad value while in FAULT does not increment the count.
- Force 260 errors with re-lock between each -> err_count saturates at 255. clr_err=1 -> err_sticky=0, err_count=0. clr_err coincident with an error -> err_count=1.
- Assert rst low mid-sequence for a partial cycle (async) -> outputs 0 immediately. After release, the first sample is captured unchecked (e.g. gray 111 gives no step_err).
